// File: rtl/bsg_clkbuf_gate_seq_if.sv
// Handshake/status bundle for bsg_clkbuf_gate_seq; abort_i exists only with
// BSG_CLKBUF_GATE_SEQ_ABORT_EN defined.
interface bsg_clkbuf_gate_seq_if #(
  parameter int unsigned width_p = 16
);
  logic               v_i;
  logic [width_p-1:0] mask_i;
  logic               ready_o;
  logic [width_p-1:0] gate_en_o;
  logic               busy_o;
  logic               done_o;
`ifdef BSG_CLKBUF_GATE_SEQ_ABORT_EN
  logic               abort_i;

  modport master (output v_i, mask_i, abort_i,
                  input  ready_o, gate_en_o, busy_o, done_o);
  modport slave  (input  v_i, mask_i, abort_i,
                  output ready_o, gate_en_o, busy_o, done_o);
`else
  modport master (output v_i, mask_i,
                  input  ready_o, gate_en_o, busy_o, done_o);
  modport slave  (input  v_i, mask_i,
                  output ready_o, gate_en_o, busy_o, done_o);
`endif
endinterface

// File: rtl/bsg_clkbuf_gate_seq.sv
// Walks lane clock-gate enables toward a target mask one lane at a time, lowest
// index first, with stagger_p idle cycles per toggle. Abort via BSG_CLKBUF_GATE_SEQ_ABORT_EN.
module bsg_clkbuf_gate_seq #(
  parameter int unsigned       width_p      = 16,
  parameter int unsigned       stagger_p    = 4,
  parameter logic [width_p-1:0] reset_mask_p = '0
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bsg_clkbuf_gate_seq_if.slave  seq_if
);

  localparam int unsigned cnt_w = $clog2(stagger_p + 1);
  localparam logic [cnt_w-1:0] stagger_c = cnt_w'(stagger_p);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  if (stagger_p < 1 || stagger_p > 255) begin : g_bad_stagger
    $error("bsg_clkbuf_gate_seq: stagger_p must be in 1..255");
  end

  logic [1:0]         state_r;
  logic [width_p-1:0] gate_en_r;
  logic [width_p-1:0] target_r;
  logic [cnt_w-1:0]   cnt_r;
  logic [width_p-1:0] diff;
  logic [width_p-1:0] lowest;
  logic               abort;

`ifdef BSG_CLKBUF_GATE_SEQ_ABORT_EN
  assign abort = seq_if.abort_i;
`else
  assign abort = 1'b0;
`endif

  // Isolate the lowest differing lane (two's-complement trick).
  always_comb begin
    diff   = gate_en_r ^ target_r;
    lowest = diff & (~diff + width_p'(1));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      gate_en_r <= reset_mask_p;
      target_r  <= reset_mask_p;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (seq_if.v_i) begin
            target_r <= seq_if.mask_i;
            state_r  <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            state_r <= DONE;
          end else if (diff == '0) begin
            state_r <= DONE;
          end else begin
            gate_en_r <= gate_en_r ^ lowest;
            cnt_r     <= stagger_c;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - cnt_w'(1);
          if (abort) begin
            state_r <= DONE;
          end else if (cnt_r == cnt_w'(1)) begin
            state_r <= SCAN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign seq_if.gate_en_o = gate_en_r;
  assign seq_if.ready_o   = (state_r == IDLE);
  assign seq_if.busy_o    = (state_r != IDLE);
  assign seq_if.done_o    = (state_r == DONE);

endmodule
